// File: rtl/mmio_timer_pwm.sv
// Memory-mapped responder for the core's load/store port: four 8-bit PWM duty
// registers plus free-running microsecond and millisecond counters.
module mmio_timer_pwm #(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned US_DIV  = CLK_FREQ_HZ / 1000000;
  localparam int unsigned US_W    = $clog2(US_DIV);
  localparam logic [US_W-1:0] US_LAST = US_W'(US_DIV - 1);
  localparam logic [9:0]  MS_LAST = 10'd999;
  localparam logic [31:0] ID_WORD = 32'h5057_4D31;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [31:0]     duty_q, duty_d;
  logic [US_W-1:0] us_pre_q, us_pre_d;
  logic [9:0]      ms_pre_q, ms_pre_d;
  logic [31:0]     micros_q, micros_d;
  logic [31:0]     millis_q, millis_d;
  logic [7:0]      pwm_cnt_q, pwm_cnt_d;
  logic [3:0]      pins_q, pins_d;
  logic [31:0]     rd_word_q, rd_word_d;
  logic [1:0]      rd_off_q, rd_off_d;
  logic [2:0]      rd_funct3_q, rd_funct3_d;

  logic        wr_hit;
  logic [3:0]  wr_be;
  logic [31:0] wr_lanes;
  logic        us_tick;
  logic        ms_tick;

  // Store path: byte enables from size/alignment, data replicated across lanes.
  always_comb begin
    wr_hit   = write_mem && (write_address[31:4] == BASE_ADDR[31:4]) &&
               (write_address[3:2] == 2'b00);
    wr_be    = 4'b0000;
    wr_lanes = write_data;
    case (funct3)
      F3_B: begin
        wr_be    = 4'b0001 << write_address[1:0];
        wr_lanes = {4{write_data[7:0]}};
      end
      F3_H: begin
        if (!write_address[0]) begin
          wr_be = write_address[1] ? 4'b1100 : 4'b0011;
        end
        wr_lanes = {2{write_data[15:0]}};
      end
      F3_W: begin
        if (write_address[1:0] == 2'b00) begin
          wr_be = 4'b1111;
        end
      end
      default: wr_be = 4'b0000;
    endcase

    duty_d = duty_q;
    for (int i = 0; i < 4; i++) begin
      if (wr_hit && wr_be[i]) begin
        duty_d[i*8 +: 8] = wr_lanes[i*8 +: 8];
      end
    end
  end

  always_comb begin
    us_tick   = (us_pre_q == US_LAST);
    ms_tick   = us_tick && (ms_pre_q == MS_LAST);
    us_pre_d  = us_tick ? '0 : us_pre_q + 1'b1;
    micros_d  = micros_q + {31'd0, us_tick};
    ms_pre_d  = ms_pre_q;
    if (us_tick) begin
      ms_pre_d = ms_tick ? 10'd0 : ms_pre_q + 10'd1;
    end
    millis_d  = millis_q + {31'd0, ms_tick};
    pwm_cnt_d = pwm_cnt_q + 8'd1;
  end

  // Pins compare the current counter against the duty already in the register,
  // so a new duty shows up on the pins one cycle after the store.
  always_comb begin
    pins_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      pins_d[i] = (pwm_cnt_q < duty_q[i*8 +: 8]);
    end
  end

  always_comb begin
    rd_word_d = 32'd0;
    if (read_address[31:4] == BASE_ADDR[31:4]) begin
      case (read_address[3:2])
        2'd0:    rd_word_d = duty_q;
        2'd1:    rd_word_d = micros_q;
        2'd2:    rd_word_d = millis_q;
        default: rd_word_d = ID_WORD;
      endcase
    end
    rd_off_d    = read_address[1:0];
    rd_funct3_d = funct3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q      <= '0;
      us_pre_q    <= '0;
      ms_pre_q    <= '0;
      micros_q    <= '0;
      millis_q    <= '0;
      pwm_cnt_q   <= '0;
      pins_q      <= '0;
      rd_word_q   <= '0;
      rd_off_q    <= '0;
      rd_funct3_q <= '0;
    end else begin
      duty_q      <= duty_d;
      us_pre_q    <= us_pre_d;
      ms_pre_q    <= ms_pre_d;
      micros_q    <= micros_d;
      millis_q    <= millis_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pins_q      <= pins_d;
      rd_word_q   <= rd_word_d;
      rd_off_q    <= rd_off_d;
      rd_funct3_q <= rd_funct3_d;
    end
  end

  // Load extraction works on the registered word; misaligned half/word loads
  // fall through to the raw word.
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte   = rd_word_q[{rd_off_q, 3'b000} +: 8];
    rd_half   = rd_off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    read_data = rd_word_q;
    case (rd_funct3_q)
      F3_B:  read_data = {{24{rd_byte[7]}}, rd_byte};
      F3_BU: read_data = {24'd0, rd_byte};
      F3_H:  if (!rd_off_q[0]) read_data = {{16{rd_half[15]}}, rd_half};
      F3_HU: if (!rd_off_q[0]) read_data = {16'd0, rd_half};
      default: read_data = rd_word_q;
    endcase
  end

  assign led   = pins_q[0];
  assign red   = pins_q[1];
  assign green = pins_q[2];
  assign blue  = pins_q[3];

endmodule

// File: tb/tb_mmio_timer_pwm.sv
// Directed and randomized checks of mmio_timer_pwm against a register-level
// model: byte-array duty register and cycle-count-derived timers.
module tb_mmio_timer_pwm;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;
  localparam logic [31:0] ID   = 32'h5057_4D31;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_mem = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] write_address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_address = 32'd0;
  logic [31:0] read_data;
  logic        led, red, green, blue;

  mmio_timer_pwm #(.CLK_FREQ_HZ(12000000), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .write_mem(write_mem), .funct3(funct3),
    .write_address(write_address), .write_data(write_data),
    .read_address(read_address), .read_data(read_data),
    .led(led), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  // Clock edges seen since the last reset release; timers are derived from it.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int          errors = 0;
  int          checks = 0;
  logic [31:0] duty_m = 32'd0;
  logic [31:0] micros_delta = 32'd0;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] micros_m();
    logic [31:0] base;
    base = 32'(cyc / 12);
    return base + micros_delta;
  endfunction

  function automatic logic [31:0] word_m(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return duty_m;
      2'd1:    return micros_m();
      2'd2:    return 32'(cyc / 12000);
      default: return ID;
    endcase
  endfunction

  function automatic logic [31:0] load_m(input logic [31:0] w, input logic [1:0] off,
                                         input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * int'(off)));
    h = 16'(w >> (16 * int'(off[1])));
    case (f3)
      3'd0: return {{24{b[7]}}, b};
      3'd4: return {24'd0, b};
      3'd1: return off[0] ? w : {{16{h[15]}}, h};
      3'd5: return off[0] ? w : {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic store_m(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
    if (!we || a[31:4] != BASE[31:4] || a[3:2] != 2'd0) return;
    case (f3)
      3'd0: duty_m[8 * int'(a[1:0]) +: 8] = d[7:0];
      3'd1: if (!a[0]) duty_m[16 * int'(a[1]) +: 16] = d[15:0];
      3'd2: if (a[1:0] == 2'd0) duty_m = d;
      default: ;
    endcase
  endtask

  // One bus cycle, entered and left on a falling edge.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] wa,
                      input logic [31:0] wd, input logic [31:0] ra, input string tag);
    logic [31:0] exp;
    write_mem = we; funct3 = f3; write_address = wa; write_data = wd; read_address = ra;
    exp = load_m(word_m(ra), ra[1:0], f3);
    store_m(we, f3, wa, wd);
    @(negedge clk);
    write_mem = 1'b0;
    check(tag, read_data, exp);
  endtask

  task automatic pin_count(input int n, input string tag);
    int c0, c1, c2, c3;
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int i = 0; i < n; i++) begin
      c0 += int'(led); c1 += int'(red); c2 += int'(green); c3 += int'(blue);
      @(negedge clk);
    end
    check({tag, "_led"},   32'(c0), 32'(int'(duty_m[7:0])   * n / 256));
    check({tag, "_red"},   32'(c1), 32'(int'(duty_m[15:8])  * n / 256));
    check({tag, "_green"}, 32'(c2), 32'(int'(duty_m[23:16]) * n / 256));
    check({tag, "_blue"},  32'(c3), 32'(int'(duty_m[31:24]) * n / 256));
  endtask

  task automatic do_reset();
    write_mem = 1'b0;
    rst_n = 1'b0;
    duty_m = 32'd0;
    micros_delta = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_read_data", read_data, 32'd0);
    check("rst_pins", {28'd0, led, red, green, blue}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic        we, seen_zero;
    logic [2:0]  f3;
    logic [31:0] wa, ra;
    bit          reached;

    @(negedge clk);
    do_reset();

    xact(0, 3'd2, 32'd0, 32'd0, BASE + 32'h4, "micros_first");
    check("micros_first_zero", read_data, 32'd0);
    xact(0, 3'd2, 32'd0, 32'd0, BASE + 32'hC, "id_lw");

    // Byte store into lane 2, collision read returns pre-write word
    xact(1, 3'd0, BASE + 32'h2, 32'h0000_00AB, BASE, "sb_collision");
    xact(0, 3'd2, 32'd0, 32'd0, BASE, "lw_after_sb");
    check("lw_after_sb_const", read_data, 32'h00AB_0000);
    xact(0, 3'd0, 32'd0, 32'd0, BASE + 32'h2, "lb_sign");
    xact(0, 3'd4, 32'd0, 32'd0, BASE + 32'h2, "lbu_zero");
    xact(1, 3'd1, BASE + 32'h1, 32'h0000_1234, BASE + 32'h2, "sh_misaligned");
    xact(1, 3'd2, BASE + 32'h2, 32'hDEAD_BEEF, BASE + 32'h2, "sw_misaligned_rd");
    xact(1, 3'd2, BASE + 32'h4, 32'hFFFF_FFFF, BASE + 32'h4, "sw_micros");
    xact(0, 3'd2, 32'd0, 32'd0, BASE + 32'h4, "micros_unaffected");
    xact(0, 3'd2, BASE, 32'h1122_3344, BASE, "nowrite");
    xact(0, 3'd5, 32'd0, 32'd0, BASE + 32'h2, "lhu_dutyhi");
    xact(0, 3'd2, 32'd0, 32'd0, BASE, "duty_unchanged");
    check("duty_unchanged_const", read_data, 32'h00AB_0000);

    xact(1, 3'd2, BASE, 32'h00FF_8000, BASE, "sw_pwm");
    @(negedge clk);
    pin_count(512, "pwm512");

    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      wa = ($urandom_range(0, 3) != 0) ? BASE + 32'($urandom_range(0, 15)) : $urandom;
      ra = ($urandom_range(0, 3) != 0) ? BASE + 32'($urandom_range(0, 15)) : $urandom;
      xact(we, f3, wa, $urandom, ra, $sformatf("rand%0d", i));
    end

    for (int k = 0; k < 2; k++) begin
      xact(1, 3'd2, BASE, $urandom, BASE + 32'hC, "rand_sw");
      @(negedge clk);
      pin_count(256, "rand_pwm");
    end

    do_reset();
    reached = 1'b0;
    for (int i = 0; i < 13000 && !reached; i++) begin
      if (cyc == 12000) reached = 1'b1;
      else @(negedge clk);
    end
    check("cyc_reach_12000", {31'd0, reached}, 32'd1);
    xact(0, 3'd2, 32'd0, 32'd0, BASE + 32'h4, "micros_model");
    check("micros_1000", read_data, 32'd1000);
    xact(0, 3'd2, 32'd0, 32'd0, BASE + 32'h8, "millis_model");
    check("millis_1", read_data, 32'd1);

    dut.micros_q <= 32'hFFFF_FFFF;
    micros_delta = 32'hFFFF_FFFF - 32'(cyc / 12);
    seen_zero = 1'b0;
    for (int i = 0; i < 14; i++) begin
      xact(0, 3'd2, 32'd0, 32'd0, BASE + 32'h4, "micros_wrap");
      if (read_data == 32'd0) seen_zero = 1'b1;
    end
    check("micros_wrapped_to_0", {31'd0, seen_zero}, 32'd1);

    xact(1, 3'd2, BASE, 32'hFFFF_FFFF, BASE, "sw_full");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    duty_m = 32'd0;
    micros_delta = 32'd0;
    #1;
    check("async_rst_pins", {28'd0, led, red, green, blue}, 32'd0);
    check("async_rst_read", read_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 3'd2, 32'd0, 32'd0, BASE, "duty_after_rst");
    check("duty_after_rst_const", read_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
